// File: rtl/raster_engine.sv
// Fixed-function rasterizer: NOP/FILL/POINT/RECT/LINE into a row-major
// framebuffer, one registered pixel write per clock.
module raster_engine #(
  parameter int FB_WIDTH  = 214,
  parameter int FB_HEIGHT = 160,
  parameter int COORD_W   = 8,
  parameter int COLOUR_W  = 3,
  parameter int ADDR_W    = 16
) (
  input  logic                clk,
  input  logic                rst_async,
  input  logic [2:0]          command,
  input  logic [COORD_W-1:0]  x0,
  input  logic [COORD_W-1:0]  y0,
  input  logic [COORD_W-1:0]  x1,
  input  logic [COORD_W-1:0]  y1,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                execute_request,
  output logic                busy,
  output logic [ADDR_W-1:0]   fb_addr,
  output logic                fb_write_en,
  output logic [COLOUR_W-1:0] fb_pixel
);

  localparam int EW = COORD_W + 3;
  localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(FB_WIDTH);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_POINT, S_RECT, S_LINE, S_NOP
  } state_t;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [COLOUR_W-1:0]   r_colour;
  logic [COORD_W-1:0]    r_x;
  logic [COORD_W-1:0]    r_y;
  logic [COORD_W-1:0]    r_xl;
  logic [COORD_W-1:0]    r_xe;
  logic [COORD_W-1:0]    r_ye;
  logic signed [EW-1:0]  r_dx;
  logic signed [EW-1:0]  r_dy;
  logic signed [EW-1:0]  r_err;
  logic                  r_sx;
  logic                  r_sy;

  function automatic logic f_vis(input logic [COORD_W-1:0] x,
                                 input logic [COORD_W-1:0] y);
    return (32'(x) < FB_WIDTH) && (32'(y) < FB_HEIGHT);
  endfunction

  // Accept-time values: normalised rect corners, line deltas, start address
  logic                  w_fill;
  logic                  w_rect;
  logic [COORD_W-1:0]    w_xl;
  logic [COORD_W-1:0]    w_xh;
  logic [COORD_W-1:0]    w_yl;
  logic [COORD_W-1:0]    w_yh;
  logic [COORD_W-1:0]    w_sx0;
  logic [COORD_W-1:0]    w_sy0;
  logic [ADDR_W-1:0]     w_saddr;
  logic signed [EW-1:0]  w_ldx;
  logic signed [EW-1:0]  w_ldy;
  state_t                w_cmd_state;

  assign w_fill  = (command == 3'd1);
  assign w_rect  = (command == 3'd3);
  assign w_xl    = (x0 < x1) ? x0 : x1;
  assign w_xh    = (x0 < x1) ? x1 : x0;
  assign w_yl    = (y0 < y1) ? y0 : y1;
  assign w_yh    = (y0 < y1) ? y1 : y0;
  assign w_sx0   = w_fill ? '0 : (w_rect ? w_xl : x0);
  assign w_sy0   = w_fill ? '0 : (w_rect ? w_yl : y0);
  assign w_saddr = ADDR_W'(w_sy0) * W_A + ADDR_W'(w_sx0);
  assign w_ldx   = (x1 >= x0) ? $signed(EW'(x1 - x0))
                              : $signed(EW'(x0 - x1));
  assign w_ldy   = (y1 >= y0) ? -$signed(EW'(y1 - y0))
                              : -$signed(EW'(y0 - y1));

  always_comb begin
    case (command)
      3'd1:    w_cmd_state = S_FILL;
      3'd2:    w_cmd_state = S_POINT;
      3'd3:    w_cmd_state = S_RECT;
      3'd4:    w_cmd_state = S_LINE;
      default: w_cmd_state = S_NOP;
    endcase
  end

  // Next pixel, stepped incrementally from the one being presented
  logic signed [EW-1:0]  w_e2;
  logic [COORD_W-1:0]    w_nx;
  logic [COORD_W-1:0]    w_ny;
  logic [ADDR_W-1:0]     w_naddr;
  logic signed [EW-1:0]  w_nerr;
  logic                  w_last;

  assign w_e2 = r_err <<< 1;

  always_comb begin
    w_nx    = r_x;
    w_ny    = r_y;
    w_naddr = r_addr;
    w_nerr  = r_err;
    w_last  = 1'b1;
    case (r_state)
      S_FILL: begin
        w_last  = (r_addr == LAST_A);
        w_naddr = r_addr + 1'b1;
      end
      S_RECT: begin
        w_last = (r_x == r_xe) && (r_y == r_ye);
        if (r_x == r_xe) begin
          w_nx    = r_xl;
          w_ny    = r_y + 1'b1;
          w_naddr = r_addr + W_A - ADDR_W'(r_xe - r_xl);
        end else begin
          w_nx    = r_x + 1'b1;
          w_naddr = r_addr + 1'b1;
        end
      end
      S_LINE: begin
        w_last = (r_x == r_xe) && (r_y == r_ye);
        if (w_e2 >= r_dy) begin
          w_nerr  = w_nerr + r_dy;
          w_nx    = r_sx ? r_x - 1'b1 : r_x + 1'b1;
          w_naddr = r_sx ? w_naddr - 1'b1 : w_naddr + 1'b1;
        end
        if (w_e2 <= r_dx) begin
          w_nerr  = w_nerr + r_dx;
          w_ny    = r_sy ? r_y - 1'b1 : r_y + 1'b1;
          w_naddr = r_sy ? w_naddr - W_A : w_naddr + W_A;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_colour <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_xl     <= '0;
      r_xe     <= '0;
      r_ye     <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_err    <= '0;
      r_sx     <= 1'b0;
      r_sy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (execute_request) begin
            r_state  <= w_cmd_state;
            r_busy   <= 1'b1;
            r_colour <= colour;
            r_x      <= w_sx0;
            r_y      <= w_sy0;
            r_addr   <= w_saddr;
            r_xl     <= w_xl;
            r_xe     <= w_rect ? w_xh : x1;
            r_ye     <= w_rect ? w_yh : y1;
            r_dx     <= w_ldx;
            r_dy     <= w_ldy;
            r_err    <= w_ldx + w_ldy;
            r_sx     <= (x1 < x0);
            r_sy     <= (y1 < y0);
            r_we     <= (w_cmd_state != S_NOP) && f_vis(w_sx0, w_sy0);
          end
        end
        default: begin
          if (w_last) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_we    <= 1'b0;
          end else begin
            r_x    <= w_nx;
            r_y    <= w_ny;
            r_addr <= w_naddr;
            r_err  <= w_nerr;
            r_we   <= f_vis(w_nx, w_ny);
          end
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign fb_addr     = r_addr;
  assign fb_write_en = r_we;
  assign fb_pixel    = r_colour;

endmodule
